// File: rtl/if_fetch_if.sv
// Instruction memory req/ack bus between the fetch stage and instruction memory.
interface if_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/if_fetch.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake, takes redirects.
// IF_MISALIGN_EXC_EN: misaligned redirect targets raise if_misalign instead of fetching.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    if_fetch_if.master  mem,
    output logic        stallreq_if,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
`ifdef IF_MISALIGN_EXC_EN
    ,
    output logic        if_misalign
`endif
);

    typedef enum logic [1:0] {FETCH, READY, FLUSH} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] tgt;
    logic        tgt_mis;
    logic        mis_q, mis_d;

`ifdef IF_MISALIGN_EXC_EN
    assign tgt     = branch_target;
    assign tgt_mis = |branch_target[1:0];
    assign if_misalign = mis_q;
`else
    assign tgt     = {branch_target[31:2], 2'b00};
    assign tgt_mis = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{branch_target[1:0], stall[5:2], stall[0]};

    assign mem.mem_req  = (state_q != READY);
    assign mem.mem_addr = pc_q;
    assign stallreq_if  = (state_q != READY);
    assign if_pc        = (state_q == READY) ? pc_q : 32'h0;
    assign if_inst      = (state_q == READY) ? inst_q : 32'h0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        redir_d = redir_q;
        mis_d   = mis_q;
        unique case (state_q)
            FETCH: begin
                if (branch_flag && tgt_mis) begin
                    pc_d    = tgt;
                    inst_d  = 32'h0;
                    mis_d   = 1'b1;
                    state_d = READY;
                end else if (mem.mem_ack && !branch_flag) begin
                    inst_d  = mem.mem_rdata;
                    state_d = READY;
                end else if (mem.mem_ack) begin
                    pc_d    = tgt;
                end else if (branch_flag) begin
                    redir_d = tgt;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // in-flight response belongs to the old path and is discarded
                if (branch_flag && tgt_mis) begin
                    pc_d    = tgt;
                    inst_d  = 32'h0;
                    mis_d   = 1'b1;
                    state_d = READY;
                end else if (mem.mem_ack) begin
                    pc_d    = branch_flag ? tgt : redir_q;
                    state_d = FETCH;
                end else if (branch_flag) begin
                    redir_d = tgt;
                end
            end
            READY: begin
                if (branch_flag && tgt_mis) begin
                    pc_d    = tgt;
                    inst_d  = 32'h0;
                    mis_d   = 1'b1;
                end else if (branch_flag) begin
                    pc_d    = tgt;
                    mis_d   = 1'b0;
                    state_d = FETCH;
                end else if (!stall[1]) begin
                    pc_d    = pc_q + PC_STEP;
                    mis_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            redir_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            redir_q <= redir_d;
            mis_q   <= mis_d;
        end
    end

endmodule
